// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-side MMU arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ARB_PORTS = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic tlbr;
    logic pil;
    logic pis;
    logic ppi;
    logic pme;
  } mmu_excp_t;

  function automatic logic [DMEM_ARB_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// req/addr_ok/data_ok split-transaction bundle; the requester side is master, the responder side slave.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  mmu_excp_t   excp;

  modport master (
    output req, addr, we, size, wstrb, wdata,
    input  addr_ok, data_ok, rdata, excp
  );

  modport slave (
    input  req, addr, we, size, wstrb, wdata,
    output addr_ok, data_ok, rdata, excp
  );

endinterface

// File: rtl/dmem_arbiter_owner_fifo.sv
// In-order 1-bit owner-tag FIFO; a pop in the same cycle frees a slot for a push while full.
module dmem_arbiter_owner_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == FULL_CNT);
  assign dout_o    = mem_q[rptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-side MMU request port between two requesters and routes responses back in order.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: port 0 priority).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  up0,
  dmem_arbiter_if.slave  up1,
  dmem_arbiter_if.master mmu
);

  logic [DMEM_ARB_PORTS-1:0] req_s;
  mem_req_t                  fields_s [DMEM_ARB_PORTS];
  mem_req_t                  sel_s;
  logic [DMEM_ARB_PORTS-1:0] grant_oh_s;
  logic [DMEM_ARB_PORTS-1:0] head_oh_s;

  logic lock_valid_q, lock_valid_d;
  logic lock_port_q, lock_port_d;
  logic winner_s;
  logic locked_s;
  logic grant_s;
  logic grant_req_s;
  logic fifo_block_s;
  logic mmu_req_s;
  logic accept_s;
  logic pop_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic fifo_head_s;

  assign req_s       = {up1.req, up0.req};
  assign fields_s[0] = '{addr: up0.addr, we: up0.we, size: up0.size, wstrb: up0.wstrb, wdata: up0.wdata};
  assign fields_s[1] = '{addr: up1.addr, we: up1.we, size: up1.size, wstrb: up1.wstrb, wdata: up1.wdata};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  always_comb begin
    if (req_s == 2'b11) begin
      winner_s = rr_q;
    end else begin
      winner_s = req_s[1] && !req_s[0];
    end
  end

  // The port opposite the last accepted one gets priority on the next contention.
  always_comb begin
    if (accept_s) begin
      rr_d = ~grant_s;
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign winner_s = req_s[1] && !req_s[0];
`endif

  // A lock whose port has dropped req is a cancel: the other port can win in the same cycle.
  assign locked_s     = lock_valid_q && req_s[lock_port_q];
  assign grant_s      = locked_s ? lock_port_q : winner_s;
  assign grant_req_s  = req_s[grant_s];
  assign fifo_block_s = fifo_full_s && !mmu.data_ok;
  assign mmu_req_s    = grant_req_s && !fifo_block_s;
  assign accept_s     = mmu_req_s && mmu.addr_ok;
  assign pop_s        = mmu.data_ok && !fifo_empty_s;

  assign sel_s     = fields_s[grant_s];
  assign mmu.req   = mmu_req_s;
  assign mmu.addr  = sel_s.addr;
  assign mmu.we    = sel_s.we;
  assign mmu.size  = sel_s.size;
  assign mmu.wstrb = sel_s.wstrb;
  assign mmu.wdata = sel_s.wdata;

  assign grant_oh_s = port_onehot(grant_s);
  assign head_oh_s  = port_onehot(fifo_head_s);

  assign up0.addr_ok = accept_s && grant_oh_s[0];
  assign up1.addr_ok = accept_s && grant_oh_s[1];
  assign up0.excp    = (grant_req_s && grant_oh_s[0]) ? mmu.excp : '0;
  assign up1.excp    = (grant_req_s && grant_oh_s[1]) ? mmu.excp : '0;
  assign up0.data_ok = pop_s && head_oh_s[0];
  assign up1.data_ok = pop_s && head_oh_s[1];
  assign up0.rdata   = mmu.rdata;
  assign up1.rdata   = mmu.rdata;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_port_d  = lock_port_q;
    if (mmu_req_s && !mmu.addr_ok) begin
      lock_valid_d = 1'b1;
      lock_port_d  = grant_s;
    end else if (accept_s || !locked_s) begin
      lock_valid_d = 1'b0;
    end else begin
      lock_valid_d = lock_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_port_q  <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_port_q  <= lock_port_d;
    end
  end

  dmem_arbiter_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .din_i   (grant_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DEPTH = 4;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if u0 ();
  dmem_arbiter_if u1 ();
  dmem_arbiter_if mmu_bus ();

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .up0   (u0),
    .up1   (u1),
    .mmu   (mmu_bus)
  );

  int errors;
  int checks;
  int q_own[$];
  int lock_p;
  int prio;
  bit last_acc[2];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] fld(input int p);
    if (p == 1) return {u1.addr, u1.we, u1.size, u1.wstrb, u1.wdata};
    else        return {u0.addr, u0.we, u0.size, u0.wstrb, u0.wdata};
  endfunction

  task automatic set_up(input int p, input bit rq, input logic [31:0] a);
    if (p == 0) begin
      u0.req = rq; u0.addr = a; u0.we = a[4]; u0.size = a[1:0] % 2'd3; u0.wstrb = a[11:8]; u0.wdata = ~a;
    end else begin
      u1.req = rq; u1.addr = a; u1.we = a[4]; u1.size = a[1:0] % 2'd3; u1.wstrb = a[11:8]; u1.wdata = ~a;
    end
  endtask

  task automatic mmu_drv(input bit aok, input bit dok, input logic [31:0] rd, input logic [4:0] ex);
    mmu_bus.addr_ok = aok;
    mmu_bus.data_ok = dok;
    mmu_bus.rdata   = rd;
    mmu_bus.excp    = ex;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Derive expected outputs from the arbitration rules, compare, then advance the model one cycle.
  task automatic settle_check();
    logic [1:0] r;
    int g, head;
    bit any, full, ereq, acc, pop;
    logic [4:0] ex;
    #1;
    r = {u1.req, u0.req};
    if (lock_p >= 0 && r[lock_p] == 1'b1) g = lock_p;
    else if (r == 2'b11)                  g = RR_EN ? prio : 0;
    else if (r == 2'b10)                  g = 1;
    else                                  g = 0;
    any  = r[g];
    full = (q_own.size() == DEPTH);
    ereq = any && !(full && !mmu_bus.data_ok);
    acc  = ereq && mmu_bus.addr_ok;
    pop  = mmu_bus.data_ok && (q_own.size() > 0);
    head = pop ? q_own[0] : 0;
    ex   = mmu_bus.excp;
    chk("mmu_req", mmu_bus.req, ereq);
    chk("up0_addr_ok", u0.addr_ok, acc && g == 0);
    chk("up1_addr_ok", u1.addr_ok, acc && g == 1);
    chk("up0_data_ok", u0.data_ok, pop && head == 0);
    chk("up1_data_ok", u1.data_ok, pop && head == 1);
    chk("up0_excp", u0.excp, (any && g == 0) ? ex : 5'd0);
    chk("up1_excp", u1.excp, (any && g == 1) ? ex : 5'd0);
    if (any) chk("mmu_fields", {mmu_bus.addr, mmu_bus.we, mmu_bus.size, mmu_bus.wstrb, mmu_bus.wdata}, fld(g));
    if (pop) begin
      chk("up0_rdata", u0.rdata, mmu_bus.rdata);
      chk("up1_rdata", u1.rdata, mmu_bus.rdata);
    end
    last_acc[0] = acc && g == 0;
    last_acc[1] = acc && g == 1;
    if (reset) begin
      q_own.delete();
      lock_p = -1;
      prio   = 0;
    end else begin
      if (pop) void'(q_own.pop_front());
      if (acc) q_own.push_back(g);
      if (ereq && !mmu_bus.addr_ok) lock_p = g;
      else if (acc || lock_p < 0 || r[lock_p] == 1'b0) lock_p = -1;
      if (acc) prio = 1 - g;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_up(0, 1'b0, 32'h0);
    set_up(1, 1'b0, 32'h0);
    mmu_drv(1'b0, 1'b0, 32'h0, 5'h0);
    settle_check();
    tick();
    reset = 1'b0;
  endtask

  task automatic t_single();
    set_up(0, 1'b1, 32'h0000_1000);
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h15);
    settle_check();
    chk("t1_addr_ok0", u0.addr_ok, 1'b1);
    chk("t1_addr_ok1", u1.addr_ok, 1'b0);
    chk("t1_mmu_addr", mmu_bus.addr, 32'h0000_1000);
    chk("t1_excp0", u0.excp, 5'h15);
    tick();
    set_up(0, 1'b0, 32'h0);
    mmu_drv(1'b0, 1'b0, 32'h0, 5'h0);
    settle_check();
    tick();
    mmu_drv(1'b0, 1'b1, 32'h1234_5678, 5'h0);
    settle_check();
    chk("t1_data_ok0", u0.data_ok, 1'b1);
    chk("t1_rdata0", u0.rdata, 32'h1234_5678);
    chk("t1_data_ok1", u1.data_ok, 1'b0);
    tick();
  endtask

  task automatic t_lock();
    set_up(0, 1'b1, 32'h0000_2000);
    set_up(1, 1'b1, 32'h0000_3000);
    mmu_drv(1'b0, 1'b0, 32'h0, 5'h0);
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("t2_hold_addr", mmu_bus.addr, 32'h0000_2000);
      chk("t2_up1_addr_ok", u1.addr_ok, 1'b0);
      tick();
    end
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    settle_check();
    chk("t2_accept0", u0.addr_ok, 1'b1);
    tick();
    set_up(0, 1'b0, 32'h0);
    settle_check();
    chk("t2_next_addr", mmu_bus.addr, 32'h0000_3000);
    chk("t2_accept1", u1.addr_ok, 1'b1);
    tick();
    apply_reset();
    // Lock held on port 1 must beat a later port-0 request.
    set_up(1, 1'b1, 32'h0000_4000);
    mmu_drv(1'b0, 1'b0, 32'h0, 5'h0);
    settle_check();
    tick();
    set_up(0, 1'b1, 32'h0000_5000);
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    settle_check();
    chk("t2b_locked_addr", mmu_bus.addr, 32'h0000_4000);
    chk("t2b_accept1", u1.addr_ok, 1'b1);
    chk("t2b_accept0", u0.addr_ok, 1'b0);
    tick();
  endtask

  task automatic t_cancel();
    set_up(0, 1'b1, 32'h0000_6000);
    set_up(1, 1'b1, 32'h0000_7000);
    mmu_drv(1'b0, 1'b0, 32'h0, 5'h0);
    settle_check();
    tick();
    set_up(0, 1'b0, 32'h0);
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    settle_check();
    chk("t3_cancel_addr", mmu_bus.addr, 32'h0000_7000);
    chk("t3_accept1", u1.addr_ok, 1'b1);
    chk("t3_accept0", u0.addr_ok, 1'b0);
    tick();
    set_up(1, 1'b0, 32'h0);
    mmu_drv(1'b0, 1'b1, 32'h0000_BEEF, 5'h0);
    settle_check();
    chk("t3_data_ok1", u1.data_ok, 1'b1);
    chk("t3_data_ok0", u0.data_ok, 1'b0);
    tick();
    settle_check();
    chk("t3_stray", {u1.data_ok, u0.data_ok}, 2'b00);
    tick();
  endtask

  task automatic t_full();
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    for (int i = 0; i < 4; i++) begin
      set_up(0, 1'b1, 32'h0000_0100 + 32'(i * 4));
      settle_check();
      chk("t4_fill", u0.addr_ok, 1'b1);
      tick();
    end
    set_up(0, 1'b1, 32'h0000_0200);
    settle_check();
    chk("t4_full_req", mmu_bus.req, 1'b0);
    chk("t4_full_ok", u0.addr_ok, 1'b0);
    tick();
    mmu_drv(1'b1, 1'b1, 32'h0000_0055, 5'h0);
    settle_check();
    chk("t4_swap_req", mmu_bus.req, 1'b1);
    chk("t4_swap_ok", u0.addr_ok, 1'b1);
    chk("t4_swap_data", u0.data_ok, 1'b1);
    tick();
    set_up(0, 1'b1, 32'h0000_0204);
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    settle_check();
    chk("t4_still_full", mmu_bus.req, 1'b0);
    tick();
  endtask

  task automatic t_interleave();
    int ports[4] = '{0, 1, 1, 0};
    logic [31:0] vals[4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    for (int i = 0; i < 4; i++) begin
      set_up(ports[i], 1'b1, 32'h0000_8000 + 32'(i));
      set_up(1 - ports[i], 1'b0, 32'h0);
      settle_check();
      chk("t5_accept", {u1.addr_ok, u0.addr_ok}, (ports[i] == 1) ? 2'b10 : 2'b01);
      tick();
    end
    set_up(0, 1'b0, 32'h0);
    set_up(1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      mmu_drv(1'b0, 1'b1, vals[i], 5'h0);
      settle_check();
      chk("t5_route", {u1.data_ok, u0.data_ok}, (ports[i] == 1) ? 2'b10 : 2'b01);
      chk("t5_rdata", (ports[i] == 1) ? u1.rdata : u0.rdata, vals[i]);
      tick();
    end
  endtask

  task automatic t_alternate();
    logic [1:0] exp_oh;
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    for (int i = 0; i < 4; i++) begin
      set_up(0, 1'b1, 32'h0000_9000 + 32'(i));
      set_up(1, 1'b1, 32'h0000_A000 + 32'(i));
      exp_oh = (RR_EN && (i % 2 == 1)) ? 2'b10 : 2'b01;
      settle_check();
      chk("t6_grant", {u1.addr_ok, u0.addr_ok}, exp_oh);
      tick();
    end
  endtask

  task automatic t_reset_mid();
    set_up(0, 1'b1, 32'h0000_B000);
    mmu_drv(1'b1, 1'b0, 32'h0, 5'h0);
    settle_check();
    tick();
    settle_check();
    tick();
    apply_reset();
    mmu_drv(1'b0, 1'b1, 32'h0000_0099, 5'h0);
    settle_check();
    chk("t7_stray_after_reset", {u1.data_ok, u0.data_ok}, 2'b00);
    tick();
  endtask

  task automatic t_random();
    bit cur;
    bit dok;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        cur = (p == 0) ? u0.req : u1.req;
        if (!cur || last_acc[p]) set_up(p, $urandom_range(0, 9) < 7, $urandom());
        else if ($urandom_range(0, 99) < 8) set_up(p, 1'b0, $urandom());
      end
      if (q_own.size() > 0) dok = ($urandom_range(0, 1) == 1);
      else                  dok = ($urandom_range(0, 29) == 0);
      mmu_drv($urandom_range(0, 9) < 6, dok, $urandom(), 5'($urandom()));
      settle_check();
      tick();
      if (c % 1000 == 500) apply_reset();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    lock_p = -1;
    prio   = 0;
    last_acc[0] = 1'b0;
    last_acc[1] = 1'b0;
    reset = 1'b1;
    set_up(0, 1'b0, 32'h0);
    set_up(1, 1'b0, 32'h0);
    mmu_drv(1'b0, 1'b0, 32'h0, 5'h1f);
    @(posedge clk);
    @(negedge clk);
    settle_check();
    chk("rst_mmu_req", mmu_bus.req, 1'b0);
    chk("rst_addr_ok", {u1.addr_ok, u0.addr_ok}, 2'b00);
    chk("rst_data_ok", {u1.data_ok, u0.data_ok}, 2'b00);
    chk("rst_excp", {u1.excp, u0.excp}, 10'd0);
    tick();
    reset = 1'b0;
    t_single();
    apply_reset();
    t_lock();
    apply_reset();
    t_cancel();
    apply_reset();
    t_full();
    apply_reset();
    t_interleave();
    apply_reset();
    t_alternate();
    apply_reset();
    t_reset_mid();
    apply_reset();
    t_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
